// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Control bundle between the multicycle RV32I control FSM and
//               the shared datapath (instruction/status in, selects and
//               enables out, plus debug state and retired-instruction count).
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  // Datapath -> controller
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  // Controller -> datapath
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_src;
  logic             reg_write;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  // Controller side
  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
           illegal, state, retired
  );

  // Datapath side
  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
           illegal, state, retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main control FSM of the multicycle RV32I core. Sequences the
//               shared memory/ALU/register-file datapath through fetch,
//               decode, execute, memory and writeback, stalls memory states
//               on mem_ready and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  multicycle_controller_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_ready;
  logic             w_retire;
  logic [1:0]       w_imm_dec;

  logic             w_pc_write;
  logic             w_adr_src;
  logic             w_mem_write;
  logic             w_ir_write;
  logic [1:0]       w_result_src;
  logic [1:0]       w_alu_src_a;
  logic [1:0]       w_alu_src_b;
  logic [1:0]       w_alu_op;
  logic [1:0]       w_imm_src;
  logic             w_reg_write;
  logic             w_illegal;

  // Memory-ready qualifier; a memory with no handshake always completes.
  generate
    if (MEM_HANDSHAKE) begin : g_handshake
      assign w_ready = bus.mem_ready;
    end else begin : g_no_handshake
      assign w_ready = 1'b1;
    end
  endgenerate

  // Immediate format decoded straight from the opcode.
  always_comb begin
    case (bus.op)
      OP_SW:   w_imm_dec = 2'b01;
      OP_BEQ:  w_imm_dec = 2'b10;
      OP_JAL:  w_imm_dec = 2'b11;
      default: w_imm_dec = 2'b00;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; unknown opcodes and unused encodings fall back to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Control outputs as a function of state plus the ready/zero qualifiers.
  always_comb begin
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_imm_src    = (r_state <= S_JAL) ? w_imm_dec : 2'b00;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = w_ready;
        w_pc_write   = w_ready;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: w_illegal = 1'b0;
          default:                                  w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_pc_write  = bus.zero;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
      end
      default: begin
        w_imm_src = 2'b00;
      end
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BEQ)   || ((r_state == S_MEMWRITE) && w_ready);

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + c_cnt_one;
    end
  end

  assign bus.pc_write   = w_pc_write;
  assign bus.adr_src    = w_adr_src;
  assign bus.mem_write  = w_mem_write;
  assign bus.ir_write   = w_ir_write;
  assign bus.result_src = w_result_src;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.imm_src    = w_imm_src;
  assign bus.reg_write  = w_reg_write;
  assign bus.illegal    = w_illegal;
  assign bus.state      = r_state;
  assign bus.retired    = r_retired;

endmodule
`default_nettype wire
